// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch aligner: default geometry, status codes,
// head-entry classification and count-field width helper.
package fetch_pkg;

  localparam int LINE_BYTES_DEF = 8;
  localparam int WIN_BYTES_DEF  = 16;
  localparam int STATUS_W_DEF   = 4;
  localparam int MIN_FAULT_DEF  = 14;
  localparam int GP_FAULT_DEF   = 15;
  localparam int PF_FAULT_DEF   = 14;

  typedef enum logic [2:0] {
    HEAD_NONE  = 3'd0,
    HEAD_DATA  = 3'd1,
    HEAD_GP    = 3'd2,
    HEAD_PF    = 3'd3,
    HEAD_OTHER = 3'd4
  } head_kind_e;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/fetch_aligner_chk.sv
// Protocol checks for the fetch aligner: decode never over-consumes and the
// window never overfills.
module fetch_aligner_chk #(
  parameter int WIN_BYTES = 16,
  parameter int CNT_W     = 5
) (
  input logic             clk,
  input logic             rst_n,
  input logic [CNT_W-1:0] dec_consume,
  input logic [CNT_W-1:0] occ
);

  a_consume_le_occ: assert property (@(posedge clk) disable iff (!rst_n) dec_consume <= occ);
  a_occ_bounded:    assert property (@(posedge clk) disable iff (!rst_n) occ <= CNT_W'(WIN_BYTES));

endmodule

// File: rtl/fetch_byte_merge.sv
// Combinational window update: drop the consumed bytes from the front and
// append the accepted head bytes directly behind the surviving ones.
module fetch_byte_merge #(
  parameter int LINE_BYTES = 8,
  parameter int WIN_BYTES  = 16,
  parameter int CNT_W      = 5
) (
  input  logic [8*WIN_BYTES-1:0]  win_in,
  input  logic [CNT_W-1:0]        occ,
  input  logic [CNT_W-1:0]        cons,
  input  logic [8*LINE_BYTES-1:0] line,
  input  logic [CNT_W-1:0]        n,
  input  logic                    append,
  output logic [8*WIN_BYTES-1:0]  win_out,
  output logic [CNT_W-1:0]        occ_out
);

  logic [CNT_W-1:0]        base;
  logic [CNT_W-1:0]        off;
  logic [8*WIN_BYTES-1:0]  shifted;
  logic [8*LINE_BYTES-1:0] line_sh;
  logic [7:0]              byte_v;

  // shift, insert and zero everything beyond the new occupancy
  always_comb begin
    win_out = '0;
    off     = '0;
    line_sh = '0;
    byte_v  = 8'h00;
    base    = occ - cons;
    if (append) begin
      occ_out = base + n;
    end else begin
      occ_out = base;
    end
    shifted = win_in >> {cons, 3'b000};
    for (int i = 0; i < WIN_BYTES; i++) begin
      off     = CNT_W'(i) - base;
      line_sh = line >> {off, 3'b000};
      if (CNT_W'(i) >= occ_out) begin
        byte_v = 8'h00;
      end else if (append && (CNT_W'(i) >= base) && (off < n)) begin
        byte_v = line_sh[7:0];
      end else begin
        byte_v = shifted[8*i +: 8];
      end
      win_out[8*i +: 8] = byte_v;
    end
  end

endmodule

// File: rtl/fetch_aligner.sv
// Drains prefetch-FIFO lines into a byte window consumed by decode.
// Optional FETCH_ALIGN_PERF_EN adds stall / consumed-byte counters.
module fetch_aligner
  import fetch_pkg::*;
#(
  parameter int  LINE_BYTES = LINE_BYTES_DEF,
  parameter int  WIN_BYTES  = WIN_BYTES_DEF,
  parameter int  STATUS_W   = STATUS_W_DEF,
  parameter int  MIN_FAULT  = MIN_FAULT_DEF,
  parameter int  GP_FAULT   = GP_FAULT_DEF,
  parameter int  PF_FAULT   = PF_FAULT_DEF,
  localparam int CNT_W      = cnt_width(WIN_BYTES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pr_reset,
  input  logic [31:0]                      wr_eip,
  output logic [31:0]                      prefetch_eip,
  output logic                             prefetchfifo_accept_do,
  input  logic [STATUS_W+8*LINE_BYTES-1:0] prefetchfifo_accept_data,
  input  logic                             prefetchfifo_accept_empty,
  output logic [CNT_W-1:0]                 fetch_valid,
  output logic [8*WIN_BYTES-1:0]           fetch,
  output logic                             fetch_limit,
  output logic                             fetch_page_fault,
  input  logic [CNT_W-1:0]                 dec_consume
`ifdef FETCH_ALIGN_PERF_EN
  ,
  output logic [31:0]                      perf_stall_cnt,
  output logic [31:0]                      perf_byte_cnt
`endif
);

  logic [8*WIN_BYTES-1:0]  win_buf;
  logic [CNT_W-1:0]        occ;
  logic [8*WIN_BYTES-1:0]  win_next;
  logic [CNT_W-1:0]        occ_next;
  logic [STATUS_W-1:0]     status;
  logic [8*LINE_BYTES-1:0] line;
  head_kind_e              head_kind;
  logic [CNT_W-1:0]        n;
  logic [CNT_W-1:0]        cons;
  logic [CNT_W:0]          fill;

  assign status       = prefetchfifo_accept_data[STATUS_W+8*LINE_BYTES-1 -: STATUS_W];
  assign line         = prefetchfifo_accept_data[8*LINE_BYTES-1:0];
  assign prefetch_eip = wr_eip;
  assign fetch        = win_buf;
  assign fetch_valid  = occ;

  // classify the FIFO head; fault codes are checked before the data range
  always_comb begin
    head_kind = HEAD_NONE;
    if (prefetchfifo_accept_empty) begin
      head_kind = HEAD_NONE;
    end else if (status == STATUS_W'(GP_FAULT)) begin
      head_kind = HEAD_GP;
    end else if (status == STATUS_W'(PF_FAULT)) begin
      head_kind = HEAD_PF;
    end else if (status >= STATUS_W'(MIN_FAULT)) begin
      head_kind = HEAD_OTHER;
    end else begin
      head_kind = HEAD_DATA;
    end
  end

  // fault flags follow the head directly, independent of window occupancy
  always_comb begin
    fetch_limit      = 1'b0;
    fetch_page_fault = 1'b0;
    case (head_kind)
      HEAD_GP: fetch_limit      = 1'b1;
      HEAD_PF: fetch_page_fault = 1'b1;
      default: begin
        fetch_limit      = 1'b0;
        fetch_page_fault = 1'b0;
      end
    endcase
  end

  // consume clamp, byte count of the head and the same-cycle refill decision
  always_comb begin
    if (dec_consume > occ) begin
      cons = occ;
    end else begin
      cons = dec_consume;
    end
    if (status > STATUS_W'(LINE_BYTES)) begin
      n = CNT_W'(LINE_BYTES);
    end else begin
      n = CNT_W'(status);
    end
    fill = {1'b0, occ} - {1'b0, cons} + {1'b0, n};
    prefetchfifo_accept_do = rst_n && !pr_reset && (head_kind == HEAD_DATA) &&
                             (fill <= (CNT_W+1)'(WIN_BYTES));
  end

  fetch_byte_merge #(
    .LINE_BYTES (LINE_BYTES),
    .WIN_BYTES  (WIN_BYTES),
    .CNT_W      (CNT_W)
  ) u_merge (
    .win_in  (win_buf),
    .occ     (occ),
    .cons    (cons),
    .line    (line),
    .n       (n),
    .append  (prefetchfifo_accept_do),
    .win_out (win_next),
    .occ_out (occ_next)
  );

  // window and occupancy registers; flush wins over consume and append
  always_ff @(posedge clk) begin
    if (!rst_n || pr_reset) begin
      win_buf <= '0;
      occ     <= '0;
    end else begin
      win_buf <= win_next;
      occ     <= occ_next;
    end
  end

`ifdef FETCH_ALIGN_PERF_EN
  // performance counters survive pipeline flushes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'd0;
      perf_byte_cnt  <= 32'd0;
    end else begin
      if ((occ == '0) && prefetchfifo_accept_empty) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
      if (!pr_reset) begin
        perf_byte_cnt <= perf_byte_cnt + 32'(cons);
      end else begin
        perf_byte_cnt <= perf_byte_cnt;
      end
    end
  end
`endif

  fetch_aligner_chk #(
    .WIN_BYTES (WIN_BYTES),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_consume (dec_consume),
    .occ         (occ)
  );

endmodule
